scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Generates the 2-bit select sequence that drives the `sel` input of the 2-to-4 one-hot decoder. It sits directly upstream of the decoder and steps `sel` through 0→1→2→3→0 at a programmable rate. It can run for a fixed number of frames or continuously, and supports single-step advances while idle. Its status pulses let downstream logic, such as a display or keypad multiplexer, align to each select change and to each complete frame.

## Interface
- `DIV`, default 4: clock cycles per select position; legal range 1..256.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a run when idle.
- `stop`  in  1  pulse; aborts a run.
- `step`  in  1  pulse; advances `sel` by one position when idle.
- `frames`  in  8  frames to run, sampled on `start`; 0 means continuous.
- `sel`  out  2  select value feeding the decoder.
- `active`  out  1  high while in RUN.
- `tick`  out  1  one-cycle pulse; `sel` changed this cycle.
- `frame_done`  out  1  one-cycle pulse; `sel` wrapped from 3 to 0 this cycle.
- `done`  out  1  one-cycle pulse; the programmed frame count is complete.

## Operation
- All outputs are registered.
- Reset values: `sel`=0, `active`=0, `tick`=0, `frame_done`=0, `done`=0.
- Reset also clears internal state: FSM=IDLE, prescaler=0, frame counter=0.
- FSM has two states, IDLE and RUN.
- Prescaler width is ceil(log2(DIV)), with a minimum of 1 bit. Frame counter is 8 bits.
- IDLE behaviour:
  - `start`=1: go to RUN, set `sel`=0, prescaler=0, latch `frames` into the frame counter. No `tick`.
  - `step`=1 with `start`=0: `sel` becomes (`sel`+1) mod 4 and `tick`=1. If the old `sel` was 3, `frame_done`=1 as well. Frame counter is untouched.
  - `start` has priority over `step`. `stop` has no effect.
- RUN behaviour:
  - Prescaler counts 0..DIV-1.
  - At the terminal count with `stop`=0: prescaler returns to 0, `sel` becomes (`sel`+1) mod 4, and `tick`=1.
  - Wrap (old `sel`=3): `frame_done`=1.
    - If the latched count is nonzero, decrement the frame counter.
    - If the counter was 1, go to IDLE in the same edge, with `done`=1 and `sel`=0 (this is also the wrap value).
    - If the latched count was 0, keep running forever and do not decrement.
  - `stop`=1: go to IDLE on the next edge. `sel` holds its current value; prescaler and frame counter clear. No `tick`, `frame_done` or `done` in that cycle, even if the terminal count coincides.
  - `start` and `step` are ignored.
- `active` = (state == RUN), registered with the state.
- Pulses: `tick`, `frame_done` and `done` are high for exactly one cycle. That cycle is the first one in which the new `sel` is visible. Otherwise they are 0.
- Reset mid-run: on the next edge all outputs return to their reset values. No `done` pulse is issued.

## Timing
- `start` sampled at edge k: at k, `active`=1 and `sel`=0.
- First advance at edge k+DIV; after that, one advance every DIV cycles.
- Each `sel` value is held for DIV cycles; one frame lasts 4·DIV cycles.
- With `frames`=N≠0, the final wrap falls at edge k+4·N·DIV. At that edge: `sel`=0, `tick`=`frame_done`=`done`=1, `active`=0.
- DIV=1: `sel` advances every cycle and `tick` stays high continuously while running.
- `step` sampled at edge j: new `sel` and `tick` at j. Back-to-back `step` pulses advance once per cycle.
- `stop` sampled at edge m: `active`=0 at m, and `sel` equals its value before m.

## Test plan
1. Reset with `rst`=1 for 2 cycles while `start`/`step` toggle. Required: `sel`=0, `active`=0 and all pulses 0 throughout and for 1 cycle after release.
2. DIV=4, `frames`=1, `start` pulse.
   - Required: `sel` reads 0,1,2,3 for 4 cycles each, with `tick` at each change.
   - At edge 16: `sel`=0, `frame_done`=`done`=1, `active`=0.
   - The decoder `out` reads 0001, 0010, 0100, 1000.
3. DIV=4, `frames`=0, run for 40 cycles. Required: `frame_done` pulses at cycles 16 and 32, `done` never asserts, `active` stays 1.
4. DIV=4, run with `stop` asserted on the terminal-count cycle while `sel`=2. Required: `sel` stays 2, no `tick`, `active`=0 next cycle, and a following `start` restarts from `sel`=0.
5. Idle, 5 consecutive `step` pulses starting from `sel`=0. Required:
   - `sel` reads 1,2,3,0,1, with `tick` every cycle.
   - `frame_done` only on the 3→0 step; `active` stays 0.
   - Raising `start` and `step` together yields RUN with `sel`=0.
6. DIV=1, `frames`=2, with `rst` asserted at cycle 5 of the run. Required: all outputs return to reset values on the next edge, with no `done` pulse; rerun to completion gives `done` at cycle 8.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 2-bit decoder select through 0..3 at a programmable
// rate, with frame-counted or continuous runs and single-step advances.
module scan_sequencer #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [7:0] frames,
    output logic [1:0] sel,
    output logic       active,
    output logic       tick,
    output logic       frame_done,
    output logic       done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    localparam logic [0:0] IDLE_S = 1'b0;
    localparam logic [0:0] RUN_S  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          fdone_q, fdone_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        fdone_d = 1'b0;
        done_d  = 1'b0;
        if (state_q == IDLE_S) begin
            if (start) begin
                state_d = RUN_S;
                sel_d   = 2'd0;
                pre_d   = '0;
                cnt_d   = frames;
            end else if (step) begin
                sel_d   = sel_q + 2'd1;
                tick_d  = 1'b1;
                fdone_d = (sel_q == 2'd3);
            end
        end else begin
            if (stop) begin
                state_d = IDLE_S;
                pre_d   = '0;
                cnt_d   = 8'd0;
            end else if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                sel_d  = sel_q + 2'd1;
                tick_d = 1'b1;
                if (sel_q == 2'd3) begin
                    fdone_d = 1'b1;
                    // a zero count means continuous: never decremented
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = IDLE_S;
                            done_d  = 1'b1;
                        end
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_S;
            sel_q   <= 2'd0;
            pre_q   <= '0;
            cnt_q   <= 8'd0;
            tick_q  <= 1'b0;
            fdone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            fdone_q <= fdone_d;
            done_q  <= done_d;
        end
    end

    assign sel        = sel_q;
    assign active     = (state_q == RUN_S);
    assign tick       = tick_q;
    assign frame_done = fdone_q;
    assign done       = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: one instance at DIV=4, one at DIV=1.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       start, stop, step;
    logic [7:0] frames;
    logic [1:0] sel_a, sel_b;
    logic       active_a, tick_a, fd_a, done_a;
    logic       active_b, tick_b, fd_b, done_b;

    int checks = 0;
    int errors = 0;

    logic [1:0] es;
    logic       ea, et, ef, ed;
    logic [3:0] dec_exp [4];
    logic [1:0] step_exp [5];

    always #5 clk = ~clk;

    scan_sequencer #(.DIV(4)) u_a (
        .clk(clk), .rst(rst_a), .start(start), .stop(stop), .step(step),
        .frames(frames), .sel(sel_a), .active(active_a), .tick(tick_a),
        .frame_done(fd_a), .done(done_a)
    );

    scan_sequencer #(.DIV(1)) u_b (
        .clk(clk), .rst(rst_b), .start(start), .stop(stop), .step(step),
        .frames(frames), .sel(sel_b), .active(active_b), .tick(tick_b),
        .frame_done(fd_b), .done(done_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] va();
        return {2'b00, sel_a, active_a, tick_a, fd_a, done_a};
    endfunction

    function automatic logic [7:0] vb();
        return {2'b00, sel_b, active_b, tick_b, fd_b, done_b};
    endfunction

    function automatic logic [7:0] ev();
        return {2'b00, es, ea, et, ef, ed};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_exp[0] = 4'b0001;
        dec_exp[1] = 4'b0010;
        dec_exp[2] = 4'b0100;
        dec_exp[3] = 4'b1000;
        step_exp[0] = 2'd1;
        step_exp[1] = 2'd2;
        step_exp[2] = 2'd3;
        step_exp[3] = 2'd0;
        step_exp[4] = 2'd1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        frames = 8'd0;

        // 1: reset with start/step toggling
        start = 1'b1;
        cyc();
        chk("rst_c1_a", va(), 8'h00);
        chk("rst_c1_b", vb(), 8'h00);
        start = 1'b0;
        step = 1'b1;
        cyc();
        chk("rst_c2_a", va(), 8'h00);
        chk("rst_c2_b", vb(), 8'h00);
        step = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc();
        chk("rst_rel_a", va(), 8'h00);
        chk("rst_rel_b", vb(), 8'h00);

        // 2: one frame at DIV=4
        frames = 8'd1;
        start = 1'b1;
        cyc();
        es = 2'd0; ea = 1'b1; et = 1'b0; ef = 1'b0; ed = 1'b0;
        chk("f1_start", va(), ev());
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            es = 2'((i / 4) % 4);
            ea = (i < 16);
            et = (i % 4 == 0);
            ef = (i == 16);
            ed = (i == 16);
            chk($sformatf("f1_e%0d", i), va(), ev());
            if (i % 4 == 1)
                chk($sformatf("f1_dec%0d", i),
                    {4'h0, 4'b0001 << sel_a}, {4'h0, dec_exp[i / 4]});
        end

        // 3: continuous run for 40 cycles, then stop
        frames = 8'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            es = 2'((i / 4) % 4);
            ea = 1'b1;
            et = (i % 4 == 0);
            ef = (i == 16) || (i == 32);
            ed = 1'b0;
            chk($sformatf("cont_e%0d", i), va(), ev());
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        es = 2'd2; ea = 1'b0; et = 1'b0; ef = 1'b0; ed = 1'b0;
        chk("cont_stop", va(), ev());

        // 4: stop coinciding with terminal count at sel=2
        start = 1'b1;
        cyc();
        start = 1'b0;
        es = 2'd0; ea = 1'b1;
        chk("tc_start", va(), ev());
        for (int i = 1; i <= 11; i++) cyc();
        es = 2'd2; ea = 1'b1;
        chk("tc_pre", va(), ev());
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        es = 2'd2; ea = 1'b0;
        chk("tc_stop", va(), ev());
        cyc();
        chk("tc_idle", va(), ev());
        start = 1'b1;
        cyc();
        start = 1'b0;
        es = 2'd0; ea = 1'b1;
        chk("tc_restart", va(), ev());
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        es = 2'd0; ea = 1'b0;
        chk("tc_stop2", va(), ev());

        // 5: back-to-back steps while idle
        step = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            es = step_exp[j];
            ea = 1'b0;
            et = 1'b1;
            ef = (j == 3);
            ed = 1'b0;
            chk($sformatf("step%0d", j), va(), ev());
        end
        step = 1'b0;
        cyc();
        es = 2'd1; ea = 1'b0; et = 1'b0; ef = 1'b0; ed = 1'b0;
        chk("step_hold", va(), ev());
        start = 1'b1;
        step = 1'b1;
        cyc();
        start = 1'b0;
        step = 1'b0;
        es = 2'd0; ea = 1'b1;
        chk("start_over_step", va(), ev());
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // 6: DIV=1, reset mid-run then full rerun
        rst_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        frames = 8'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            es = 2'(i % 4);
            ea = 1'b1;
            et = 1'b1;
            ef = (i == 4);
            ed = 1'b0;
            chk($sformatf("d1_pre%0d", i), vb(), ev());
        end
        rst_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        chk("d1_rst", vb(), 8'h00);
        cyc();
        chk("d1_rst_after", vb(), 8'h00);
        start = 1'b1;
        cyc();
        start = 1'b0;
        es = 2'd0; ea = 1'b1; et = 1'b0; ef = 1'b0; ed = 1'b0;
        chk("d1_start", vb(), ev());
        for (int i = 1; i <= 8; i++) begin
            cyc();
            es = 2'(i % 4);
            ea = (i < 8);
            et = 1'b1;
            ef = (i == 4) || (i == 8);
            ed = (i == 8);
            chk($sformatf("d1_e%0d", i), vb(), ev());
        end
        cyc();
        chk("d1_idle", vb(), 8'h00);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
